// File: rtl/display_pkg.sv
// Shared constants for the six-digit multiplexed time display: digit slots,
// blink field encodings and active-high 7-segment patterns in {g..a} order.
package display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [2:0] IDX_SEC_ONES = 3'd0;
  localparam logic [2:0] IDX_SEC_TENS = 3'd1;
  localparam logic [2:0] IDX_MIN_ONES = 3'd2;
  localparam logic [2:0] IDX_MIN_TENS = 3'd3;
  localparam logic [2:0] IDX_HR_ONES  = 3'd4;
  localparam logic [2:0] IDX_HR_TENS  = 3'd5;

  typedef enum logic [1:0] {
    BLINK_NONE = 2'd0,
    BLINK_SEC  = 2'd1,
    BLINK_MIN  = 2'd2,
    BLINK_HR   = 2'd3
  } blink_sel_e;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH = 7'h40;

  // True when the digit slot belongs to the selected blink field.
  function automatic logic in_blink_field(input logic [2:0] idx, input blink_sel_e sel);
    case (sel)
      BLINK_SEC: return (idx == IDX_SEC_ONES) || (idx == IDX_SEC_TENS);
      BLINK_MIN: return (idx == IDX_MIN_ONES) || (idx == IDX_MIN_TENS);
      BLINK_HR:  return (idx == IDX_HR_ONES)  || (idx == IDX_HR_TENS);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-high 7-segment decoder; non-decimal codes show a dash.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_DASH;
    case (code)
      4'd0: pattern = SEG_DIGIT[0];
      4'd1: pattern = SEG_DIGIT[1];
      4'd2: pattern = SEG_DIGIT[2];
      4'd3: pattern = SEG_DIGIT[3];
      4'd4: pattern = SEG_DIGIT[4];
      4'd5: pattern = SEG_DIGIT[5];
      4'd6: pattern = SEG_DIGIT[6];
      4'd7: pattern = SEG_DIGIT[7];
      4'd8: pattern = SEG_DIGIT[8];
      4'd9: pattern = SEG_DIGIT[9];
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// Scans six BCD time digits onto a multiplexed 7-segment display with per-frame
// snapshotting, field blinking and leading-zero blanking of the hours-tens digit.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 60,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] hr_ones,
  input  logic [3:0] hr_tens,
  input  logic [1:0] blink_sel,
  input  logic       lz_blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_start
);

  localparam int   PW  = $clog2(SCAN_DIV);
  localparam int   FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [PW-1:0] prescaler;
  logic [2:0]    idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  logic [NUM_DIGITS-1:0][3:0] snap_digit;
  blink_sel_e                 snap_blink;
  logic                       snap_lz;

  logic                       tick;
  logic [2:0]                 idx_next;
  logic                       new_frame;
  logic                       frame_wrap;
  logic [NUM_DIGITS-1:0][3:0] live_digit;
  logic [NUM_DIGITS-1:0][3:0] cur_digit;
  blink_sel_e                 cur_blink;
  logic                       cur_lz;
  logic                       cur_phase;
  logic [3:0]                 code;
  logic [6:0]                 pattern;
  logic                       blank;
  logic [6:0]                 seg_act;
  logic                       dp_act;
  logic [5:0]                 an_act;

  assign live_digit = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

  // The slot being loaded on a frame boundary must already see the new
  // snapshot and blink phase, so select the live values in that case.
  always_comb begin
    tick       = (prescaler == PW'(SCAN_DIV - 1));
    idx_next   = (idx == IDX_HR_TENS) ? IDX_SEC_ONES : idx + 3'd1;
    new_frame  = tick && (idx_next == IDX_SEC_ONES);
    frame_wrap = (frame_cnt == FW'(BLINK_FRAMES - 1));
    cur_digit  = new_frame ? live_digit : snap_digit;
    cur_blink  = new_frame ? blink_sel_e'(blink_sel) : snap_blink;
    cur_lz     = new_frame ? lz_blank : snap_lz;
    cur_phase  = (new_frame && frame_wrap) ? ~blink_phase : blink_phase;

    code = cur_digit[0];
    case (idx_next)
      IDX_SEC_TENS: code = cur_digit[1];
      IDX_MIN_ONES: code = cur_digit[2];
      IDX_MIN_TENS: code = cur_digit[3];
      IDX_HR_ONES:  code = cur_digit[4];
      IDX_HR_TENS:  code = cur_digit[5];
      default:      code = cur_digit[0];
    endcase

    blank = (cur_phase && in_blink_field(idx_next, cur_blink)) ||
            ((idx_next == IDX_HR_TENS) && cur_lz && (cur_digit[5] == 4'd0));

    seg_act = blank ? 7'h00 : pattern;
    dp_act  = !blank && ((idx_next == IDX_MIN_ONES) || (idx_next == IDX_HR_ONES));
    an_act  = blank ? 6'h00 : (6'b000001 << idx_next);
  end

  seg7_decoder u_dec (
    .code    (code),
    .pattern (pattern)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler   <= '0;
      idx         <= IDX_HR_TENS;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_digit  <= '0;
      snap_blink  <= BLINK_NONE;
      snap_lz     <= 1'b0;
      seg         <= {7{POL}};
      dp          <= POL;
      an          <= {6{POL}};
      frame_start <= 1'b0;
    end else begin
      prescaler   <= tick ? '0 : prescaler + PW'(1);
      frame_start <= new_frame;
      if (tick) begin
        idx <= idx_next;
        seg <= seg_act ^ {7{POL}};
        dp  <= dp_act ^ POL;
        an  <= an_act ^ {6{POL}};
      end
      if (new_frame) begin
        snap_digit  <= live_digit;
        snap_blink  <= blink_sel_e'(blink_sel);
        snap_lz     <= lz_blank;
        frame_cnt   <= frame_wrap ? '0 : frame_cnt + FW'(1);
        blink_phase <= cur_phase;
      end
    end
  end

endmodule
